aes128_dec_iter: RTL and testbench
==================================

# aes128_dec_iter

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that completes one decryption round per clock. It pairs with the team's pipelined encryption rounds and decrypts their ciphertext. It accepts one 128-bit block per valid/ready transaction, derives the round keys backwards on the fly, and presents plaintext on a valid/ready output. Only one block is in flight at a time.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ct_in/key_in are valid.
- in_ready  out  1  block can accept a new block; high only in IDLE.
- ct_in  in  128  ciphertext; byte 0 = bits [127:120], column-major (FIPS-197 order).
- key_in  in  128  round-10 key (macro off) or cipher key (macro on), same byte order.
- out_valid  out  1  pt_out is valid.
- out_ready  in  1  sink accepts pt_out.
- pt_out  out  128  plaintext, same byte order.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXPAND (macro on only), ROUND, FINAL, DONE.
- IDLE:
  - On in_valid & in_ready, capture ct_in and key_in.
  - Macro off: state <= ct_in ^ key_in; rk <= key_in; rnd <= 10; go to ROUND.
  - Macro on: rk <= key_in; rnd <= 1; go to EXPAND.
- EXPAND (macro on only):
  - rk <= forward schedule step with Rcon[rnd]; rnd++.
  - After the rnd = 10 step: state <= ct ^ rk_10; rnd <= 10; go to ROUND.
- ROUND, rnd = 10 down to 2:
  - rk_prev = inverse schedule(rk, Rcon[rnd]):
    - w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[rnd], 24'h0}
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev); rk <= rk_prev; rnd--.
  - When rnd reaches 1, go to FINAL.
- FINAL: state <= InvSubBytes(InvShiftRows(state)) ^ rk_prev(Rcon[1]); go to DONE.
- DONE: out_valid = 1, pt_out = state. On out_ready, go to IDLE.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36, from a case on rnd.
- rnd is 4 bits; values 0, 11-15 are unreachable, and the FSM returns to IDLE if it ever sees one.
- InvMixColumns uses GF(2^8) constants 0e/0b/0d/09 with reduction polynomial 0x11b.
- InvSubBytes uses 16 combinational inverse S-box lookups. The schedule uses 4 combinational forward S-box lookups. No registered table lookups inside a round.
- ct_in/key_in are ignored outside IDLE. in_valid held high during a busy period has no effect until the block returns to IDLE.
- pt_out holds its value after leaving DONE until the next FINAL writes it. It is only meaningful while out_valid = 1.

## Timing
- Reset values: in_ready = 0 during reset and 1 in the first cycle after it; out_valid = 0; busy = 0; pt_out = 0; state/rk/rnd = 0; FSM = IDLE.
- Reset asserted mid-operation aborts the block immediately with no output. The same reset values apply.
- Latency, macro off: accept at edge N; out_valid high after edge N+10 (9 ROUND + 1 FINAL).
- Latency, macro on: out_valid high after edge N+20 (10 EXPAND + 9 ROUND + 1 FINAL).
- pt_out and out_valid stay stable while out_valid & !out_ready.
- If out_ready is already high when DONE is entered, out_valid lasts exactly one cycle.
- in_ready rises the cycle after the output handshake. There is no same-cycle out→in overlap.
- Maximum throughput is one block per 12 cycles (macro off).

## Configuration
- AES_DEC_FWD_KEY_EN defined: key_in is the 128-bit cipher key and the EXPAND state is present, giving latency 20.
- AES_DEC_FWD_KEY_EN undefined: key_in must be the round-10 key. The EXPAND state and forward-step logic are not compiled, giving latency 10.

## Test plan
- Macro off, FIPS-197 App. B: ct 3925841d02dc09fbdc118597196a0b32, key_in d014f9a8c9ee2589e13f0cc8b6630ca6 -> pt_out 3243f6a8885a308d313198a2e0370734, out_valid exactly 10 cycles after accept.
- Macro off, FIPS-197 C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key_in 13111d7fe3944a17f307a78b4d2b30c5 -> pt_out 00112233445566778899aabbccddeeff.
- Macro on, C.1: key_in 000102030405060708090a0b0c0d0e0f with the same ct -> same pt, latency 20.
- Backpressure: out_ready held low for 7 cycles in DONE -> out_valid and pt_out stable and in_ready = 0 throughout; handshake completes, then in_ready = 1 on the next cycle.
- Input held: in_valid held high with a changing ct_in during busy -> only the first block is decrypted; the second block is accepted after return to IDLE and both results are correct back-to-back.
- rst pulsed at cycle 5 of a decryption -> all outputs return to their reset values; the next block decrypts correctly with nominal latency.

Source files
------------

// File: rtl/aes128_dec_iter.sv
// aes128_dec_iter: iterative AES-128 inverse cipher that runs one decryption round per clock.
// Round keys are derived backwards on the fly. Only one block is in flight at a time.
//
// Ports:
//   clk, rst             single clock; synchronous active-high reset
//   in_valid / in_ready  input handshake that carries ct_in and key_in
//                        (in_ready is high only in IDLE and never during reset)
//   ct_in  [127:0]       ciphertext; byte 0 is bits [127:120], column-major
//   key_in [127:0]       round-10 key, or the cipher key when AES_DEC_FWD_KEY_EN is defined
//   out_valid / out_ready output handshake that carries pt_out
//   pt_out [127:0]       plaintext; meaningful only while out_valid is high
//   busy                 high in every state except IDLE
//
// Handshakes: a transfer happens on the rising edge where valid and ready are both high.
// A source holds its payload stable while valid is high and ready is low.
//
// Optional feature macro AES_DEC_FWD_KEY_EN: key_in is the cipher key. An EXPAND phase of
// 10 cycles runs the forward schedule up to the round-10 key before decryption starts.
module aes128_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_ROUND  = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } fsm_e;

  // GF(2^8) multiply, reduction polynomial 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254. This also maps 0 to 0, which the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Byte (row r, column c) sits at index 4c+r. Row r is rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09);
      o[119-32*c -: 8] = gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d);
      o[111-32*c -: 8] = gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b);
      o[103-32*c -: 8] = gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  // SubWord(RotWord(w)) combined into one step.
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;   // working cipher state
  logic [127:0] rk_q, rk_d;     // current round key
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] pt_q, pt_d;     // written only in FINAL, so it holds after DONE
  logic [127:0] rk_prev, isr_isb;
  logic         rnd_ok, accept;
`ifdef AES_DEC_FWD_KEY_EN
  logic [127:0] ct_q, ct_d;     // ciphertext parked while the key is expanded
  logic [127:0] rk_next;
  logic [31:0]  f0, f1, f2, f3;
`endif

  // Datapath terms. The schedule step uses the 4 forward S-box lookups.
  always_comb begin
    logic [31:0] w0, w1, w2, w3, p3;
    w0      = rk_q[127:96];
    w1      = rk_q[95:64];
    w2      = rk_q[63:32];
    w3      = rk_q[31:0];
    p3      = w3 ^ w2;
    rk_prev = {w0 ^ sub_rot_word(p3) ^ {rcon(rnd_q), 24'h0}, w1 ^ w0, w2 ^ w1, p3};
    isr_isb = inv_sub_bytes(inv_shift_rows(blk_q));
    rnd_ok  = (rnd_q != 4'd0) && (rnd_q <= 4'd10);
    accept  = in_valid && in_ready;
  end

`ifdef AES_DEC_FWD_KEY_EN
  always_comb begin
    f0      = rk_q[127:96] ^ sub_rot_word(rk_q[31:0]) ^ {rcon(rnd_q), 24'h0};
    f1      = rk_q[95:64] ^ f0;
    f2      = rk_q[63:32] ^ f1;
    f3      = rk_q[31:0] ^ f2;
    rk_next = {f0, f1, f2, f3};
  end
`endif

  // State register plus datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      blk_q <= '0;
      rk_q  <= '0;
      rnd_q <= '0;
      pt_q  <= '0;
`ifdef AES_DEC_FWD_KEY_EN
      ct_q  <= '0;
`endif
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      rk_q  <= rk_d;
      rnd_q <= rnd_d;
      pt_q  <= pt_d;
`ifdef AES_DEC_FWD_KEY_EN
      ct_q  <= ct_d;
`endif
    end
  end

  // Next-state logic. An out-of-range rnd value is treated as corruption and drops the block.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: if (accept) begin
`ifdef AES_DEC_FWD_KEY_EN
        fsm_d = S_EXPAND;
`else
        fsm_d = S_ROUND;
`endif
      end
`ifdef AES_DEC_FWD_KEY_EN
      S_EXPAND: if (!rnd_ok) fsm_d = S_IDLE; else if (rnd_q == 4'd10) fsm_d = S_ROUND;
`endif
      S_ROUND:  if (!rnd_ok) fsm_d = S_IDLE; else if (rnd_q == 4'd2) fsm_d = S_FINAL;
      S_FINAL:  fsm_d = rnd_ok ? S_DONE : S_IDLE;
      S_DONE:   if (out_ready) fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  // Datapath updates for each state.
  always_comb begin
    blk_d = blk_q;
    rk_d  = rk_q;
    rnd_d = rnd_q;
    pt_d  = pt_q;
`ifdef AES_DEC_FWD_KEY_EN
    ct_d  = ct_q;
`endif
    case (fsm_q)
      S_IDLE: if (accept) begin
        rk_d = key_in;
`ifdef AES_DEC_FWD_KEY_EN
        ct_d  = ct_in;
        rnd_d = 4'd1;
`else
        blk_d = ct_in ^ key_in;
        rnd_d = 4'd10;
`endif
      end
`ifdef AES_DEC_FWD_KEY_EN
      S_EXPAND: begin
        rk_d  = rk_next;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          blk_d = ct_q ^ rk_next;
          rnd_d = 4'd10;
        end
      end
`endif
      S_ROUND: begin
        blk_d = inv_mix_columns(isr_isb ^ rk_prev);
        rk_d  = rk_prev;
        rnd_d = rnd_q - 4'd1;
      end
      S_FINAL: begin
        blk_d = isr_isb ^ rk_prev;
        pt_d  = isr_isb ^ rk_prev;
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (fsm_q == S_IDLE) && !rst;
    out_valid = (fsm_q == S_DONE);
    busy      = (fsm_q != S_IDLE);
    pt_out    = pt_q;
  end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// tb_aes128_dec_iter: directed test of aes128_dec_iter against FIPS-197 vectors. It covers
// reset values, latency, backpressure, held in_valid during a busy period, and a
// mid-operation reset.
module tb_aes128_dec_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] ct_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] pt_out;
  logic         busy;

  int nvec = 0;
  int nerr = 0;

  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_FWD_KEY_EN
  localparam int           LAT   = 20;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
`else
  localparam int           LAT   = 10;
  localparam logic [127:0] KEY_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`endif

  aes128_dec_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Scoreboard compare.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: wait (bounded) for in_ready, then present one block for one accepting edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] key);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_send", 128'(in_ready), 128'd1);
    ct_in    = ct;
    key_in   = key;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from acceptance until out_valid is seen, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_pt_out", pt_out, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 App. B with the sink already ready: out_valid lasts one cycle.
    out_ready = 1'b1;
    send(CT_B, KEY_B);
    chk("b_busy", 128'(busy), 128'd1);
    chk("b_in_ready_busy", 128'(in_ready), 128'd0);
    wait_out(lat);
    chk("b_latency", 128'(lat), 128'(LAT));
    chk("b_pt", pt_out, PT_B);
    @(posedge clk); #1;
    chk("b_one_cycle_valid", 128'(out_valid), 128'd0);
    chk("b_in_ready_after", 128'(in_ready), 128'd1);

    // FIPS-197 C.1 with backpressure held in DONE.
    out_ready = 1'b0;
    send(CT_C, KEY_C);
    wait_out(lat);
    chk("c_latency", 128'(lat), 128'(LAT));
    chk("c_pt", pt_out, PT_C);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_pt_stable", pt_out, PT_C);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);

    // in_valid held across a busy period while ct_in/key_in change randomly.
    ct_in    = CT_B;
    key_in   = KEY_B;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("held_busy", 128'(busy), 128'd1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      ct_in  = {$urandom, $urandom, $urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      lat++;
    end
    chk("held_first_latency", 128'(lat), 128'(LAT));
    chk("held_first_pt", pt_out, PT_B);
    ct_in  = CT_C;
    key_in = KEY_C;
    @(posedge clk); #1;
    chk("held_handshake_valid", 128'(out_valid), 128'd0);
    chk("held_in_ready_back", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("held_second_busy", 128'(busy), 128'd1);
    wait_out(lat);
    chk("held_second_latency", 128'(lat), 128'(LAT));
    chk("held_second_pt", pt_out, PT_C);
    @(posedge clk); #1;

    // Reset pulsed in the middle of a decryption.
    send(CT_B, KEY_B);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    chk("midrst_pt_out", pt_out, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle_ready", 128'(in_ready), 128'd1);
    chk("midrst_no_output", 128'(out_valid), 128'd0);
    send(CT_C, KEY_C);
    wait_out(lat);
    chk("midrst_latency", 128'(lat), 128'(LAT));
    chk("midrst_pt", pt_out, PT_C);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
